deal_sequencer: RTL
===================

// Module: deal_sequencer
// PURPOSE
//  Deal controller between the hand FSM and the shuffled-deck RAM. Per hand it
//  triggers the external shuffler, then serves per-street deal requests.
//  Streets are hole, flop, turn and river. It reads cards in deck order, burns
//  one card before each board street, and writes each dealt card into a
//  numbered card slot. It enforces street order and rejects out-of-order requests.
// PARAMETERS
//  CARD_W     6   width of one card code in the deck RAM
//  DECK_SIZE  52  number of cards in the deck RAM
//  ADDR_W     6   deck RAM address width; must satisfy 2**ADDR_W >= DECK_SIZE
// PORTS
//  clk            in   1       system clock
//  reset          in   1       synchronous, active-high reset
//  new_hand       in   1       pulse: start a new hand (shuffle + reset deal order)
//  first_player   in   1       player who receives the first hole card (0=P1, 1=P2)
//  deal_req       in   1       pulse: deal the street given by deal_stage
//  deal_stage     in   2       0=hole 1=flop 2=turn 3=river
//  shuffle_start  out  1       1-cycle pulse to the shuffler
//  shuffle_done   in   1       shuffler finished; sampled only in SHUFFLE
//  rd_en          out  1       deck RAM read strobe
//  rd_addr        out  ADDR_W  deck RAM address (deck pointer)
//  rd_data        in   CARD_W  deck RAM data; valid exactly 1 cycle after rd_en
//  card_wr_en     out  1       dealt-card write strobe
//  card_wr_slot   out  4       0/1=P1 c0/c1, 2/3=P2 c0/c1, 4-6=flop, 7=turn, 8=river
//  card_wr_data   out  CARD_W  dealt card (registered copy of rd_data)
//  ready          out  1       high only in READY; a deal_req is accepted only while high
//  deal_done      out  1       1-cycle pulse with the last card write of a street
//  deal_err       out  1       1-cycle pulse: deal_req rejected
// BEHAVIOUR
//  States: IDLE, SHUFFLE, READY, DEAL, DONE.
//  Reset: state=IDLE, ptr=0, exp_stage=0, all outputs 0, rd_addr=0, card_wr_slot=0.
//  IDLE -> SHUFFLE on new_hand. shuffle_start pulses on the first SHUFFLE cycle only.
//  SHUFFLE -> READY on the first cycle shuffle_done=1. On that transition: ptr=0, exp_stage=0.
//  new_hand in any non-IDLE state aborts immediately:
//   - no further rd_en or card_wr_en is issued; a write pending from the prior cycle is dropped;
//   - next state is SHUFFLE, with shuffle_start pulsing again.
//  new_hand has priority over deal_req in the same cycle.
//  Accept cycle (c0): deal_req=1, ready=1 and deal_stage==exp_stage.
//   - c0: ptr += 1 for stages 1-3 (burn card, never read); no change for stage 0.
//   - Next state is DEAL.
//   - N = 4, 3, 1, 1 cards for stages 0-3.
//  DEAL, cycles c1..cN: rd_en=1, rd_addr=ptr, ptr++ each cycle.
//  Writes, cycles c2..cN+1: card_wr_en=1 and card_wr_data=rd_data from the previous cycle.
//  DONE is cycle cN+1: the last write, plus deal_done=1.
//   - exp_stage++; after river exp_stage holds 3 and a done flag is set.
//   - Next state is READY; ready=1 again at cN+2. Latency from accept to last write is N+1 cycles.
//  Hole-card slot order (A=first_player, B=other player):
//   - A.c0, B.c0, A.c1, B.c1
//   - first_player=0 gives slots 0,2,1,3; first_player=1 gives slots 2,0,3,1.
//   - first_player is latched at c0.
//  Flop slots 4,5,6; turn slot 7; river slot 8.
//  Reject cases (deal_err=1 for one cycle; no state change; no RAM access):
//   - deal_req when ready=0;
//   - deal_stage != exp_stage;
//   - any deal_req after the river has been dealt.
//  ptr maximum per hand is 12 (< DECK_SIZE), so no wrap logic is needed.
//  shuffle_done seen outside SHUFFLE is ignored.
// TESTING
//  1. reset, new_hand, shuffle_done after 5 cycles -> shuffle_start exactly 1 pulse; ready=1 the cycle after done.
//  2. RAM[i]=i+10, first_player=0, hole req
//     -> writes (slot,data) (0,10),(2,11),(1,12),(3,13) on c2..c5; deal_done at c5; rd_addr 0..3.
//  3. Continue flop, turn, river -> flop (4,15),(5,16),(6,17); turn (7,19); river (8,21); addrs 4,8,10 never read.
//  4. deal_req stage=2 right after hole; then a 5th request after river -> deal_err pulse each time; no rd_en.
//  5. new_hand at c2 of flop deal -> no writes after c2; shuffle_start next cycle; hole deal then restarts from addr 0.
//  6. first_player=1 hole deal -> slots 2,0,3,1; reset asserted mid-deal -> all outputs 0 the following cycle.

Source files
------------

// File: rtl/deal_sequencer.sv
// deal_sequencer: starts the shuffler for each hand, then serves per-street deal
// requests (hole, flop, turn, river). It reads the shuffled deck in order, burns
// one card before each board street, and writes every dealt card into its slot.
// All strobes and data outputs are registered. ready and deal_done are decoded
// straight from the state register.
module deal_sequencer #(
  parameter int CARD_W    = 6,
  parameter int DECK_SIZE = 52,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_hand,
  input  logic              first_player,
  input  logic              deal_req,
  input  logic [1:0]        deal_stage,
  output logic              shuffle_start,
  input  logic              shuffle_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CARD_W-1:0] rd_data,
  output logic              card_wr_en,
  output logic [3:0]        card_wr_slot,
  output logic [CARD_W-1:0] card_wr_data,
  output logic              ready,
  output logic              deal_done,
  output logic              deal_err
);

  typedef enum logic [2:0] {IDLE, SHUFFLE, READY, DEAL, DONE} state_t;

  // The deck address must be able to reach every card in the deck.
  if ((2 ** ADDR_W) < DECK_SIZE) begin : g_addr_w_check
    $error("deal_sequencer: ADDR_W too narrow for DECK_SIZE");
  end

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic [1:0]          exp_stage, exp_stage_n;
  logic                river_done, river_done_n;
  logic [1:0]          stage_q, stage_n;
  logic                fp_q, fp_n;
  logic [1:0]          rd_idx, rd_idx_n;
  logic                start_q, start_n;
  logic                rd_en_q, rd_en_n;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_n;
  logic                wr_en_q, wr_en_n;
  logic [3:0]          wr_slot_q, wr_slot_n;
  logic [CARD_W-1:0]   wr_data_q, wr_data_n;
  logic                err_q, err_n;
  logic                accept;
  logic [ADDR_W-1:0]   burn;

  // Index of the last card read for a street (4, 3, 1, 1 cards).
  function automatic logic [1:0] last_idx_of(input logic [1:0] stage);
    case (stage)
      2'd0:    last_idx_of = 2'd3;
      2'd1:    last_idx_of = 2'd2;
      default: last_idx_of = 2'd0;
    endcase
  endfunction

  // Slot for the idx-th card of a street. Hole cards alternate between the
  // players starting with first_player; card 0 of both players comes first.
  function automatic logic [3:0] slot_of(input logic [1:0] stage, input logic fp,
                                         input logic [1:0] idx);
    case (stage)
      2'd0:    slot_of = {2'b00, idx[0] ^ fp, idx[1]};
      2'd1:    slot_of = 4'd4 + {2'b00, idx};
      2'd2:    slot_of = 4'd7;
      default: slot_of = 4'd8;
    endcase
  endfunction

  // Next-state, deck pointer and registered-output computation.
  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    exp_stage_n  = exp_stage;
    river_done_n = river_done;
    stage_n      = stage_q;
    fp_n         = fp_q;
    rd_idx_n     = rd_idx;
    start_n      = 1'b0;
    rd_en_n      = 1'b0;
    rd_addr_n    = '0;
    wr_en_n      = 1'b0;
    wr_slot_n    = 4'd0;
    wr_data_n    = '0;
    err_n        = 1'b0;
    accept       = (state == READY) && deal_req && (deal_stage == exp_stage) && !river_done;
    burn         = (deal_stage != 2'd0) ? ADDR_W'(1) : ADDR_W'(0);

    if (new_hand) begin
      state_n = SHUFFLE;
      start_n = 1'b1;
    end else begin
      if (rd_en_q) begin
        wr_en_n   = 1'b1;
        wr_slot_n = slot_of(stage_q, fp_q, rd_idx);
        wr_data_n = rd_data;
      end
      if (deal_req && !accept) begin
        err_n = 1'b1;
      end
      case (state)
        IDLE: begin
        end
        SHUFFLE: begin
          if (shuffle_done) begin
            state_n      = READY;
            ptr_n        = '0;
            exp_stage_n  = 2'd0;
            river_done_n = 1'b0;
          end
        end
        READY: begin
          if (accept) begin
            state_n   = DEAL;
            stage_n   = deal_stage;
            fp_n      = first_player;
            rd_idx_n  = 2'd0;
            rd_en_n   = 1'b1;
            rd_addr_n = ptr + burn;
            ptr_n     = ptr + burn + ADDR_W'(1);
          end
        end
        DEAL: begin
          if (rd_idx == last_idx_of(stage_q)) begin
            state_n = DONE;
          end else begin
            rd_en_n   = 1'b1;
            rd_addr_n = ptr;
            ptr_n     = ptr + ADDR_W'(1);
            rd_idx_n  = rd_idx + 2'd1;
          end
        end
        DONE: begin
          state_n = READY;
          if (stage_q == 2'd3) begin
            river_done_n = 1'b1;
          end else begin
            exp_stage_n = exp_stage + 2'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, deal bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      exp_stage  <= 2'd0;
      river_done <= 1'b0;
      stage_q    <= 2'd0;
      fp_q       <= 1'b0;
      rd_idx     <= 2'd0;
      start_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_slot_q  <= 4'd0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      exp_stage  <= exp_stage_n;
      river_done <= river_done_n;
      stage_q    <= stage_n;
      fp_q       <= fp_n;
      rd_idx     <= rd_idx_n;
      start_q    <= start_n;
      rd_en_q    <= rd_en_n;
      rd_addr_q  <= rd_addr_n;
      wr_en_q    <= wr_en_n;
      wr_slot_q  <= wr_slot_n;
      wr_data_q  <= wr_data_n;
      err_q      <= err_n;
    end
  end

  assign shuffle_start = start_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign card_wr_en    = wr_en_q;
  assign card_wr_slot  = wr_slot_q;
  assign card_wr_data  = wr_data_q;
  assign ready         = (state == READY);
  assign deal_done     = (state == DONE);
  assign deal_err      = err_q;

endmodule
